// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S controller-mode transmitter with a stereo frame FIFO
module i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              pcm_left,
  input  logic [DATA_WIDTH-1:0]              pcm_right,
  input  logic                               pcm_valid,
  output logic                               pcm_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun,
  output logic                               i2s_bclk,
  output logic                               i2s_lrclk,
  output logic                               i2s_sdata
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [LVL_W-1:0]        r_level;

  logic [DIV_W-1:0]        r_div;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_underrun;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_tx_left;
  logic [DATA_WIDTH-1:0]   r_tx_right;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_div_tc;
  logic                    w_fall;
  logic                    w_load;
  logic                    w_right;
  logic                    w_bit;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [CNT_W-1:0]        w_pos;
  logic [DATA_WIDTH-1:0]   w_sample;
  logic [DATA_WIDTH-1:0]   w_shifted;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = pcm_valid && !w_full;
  assign w_div_tc  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall    = enable && w_div_tc && r_bclk;
  assign w_cnt_nxt = (r_bit_cnt == CNT_W'(2 * SLOT_WIDTH - 1)) ? '0 : r_bit_cnt + 1'b1;
  assign w_load    = w_fall && (w_cnt_nxt == '0);
  // Load sees the FIFO state before this cycle's push, so a simultaneous push never bypasses
  assign w_pop     = w_load && !w_empty;

  // Bit position inside the slot that the next falling edge will present
  assign w_right   = (w_cnt_nxt >= CNT_W'(SLOT_WIDTH));
  assign w_pos     = w_right ? (w_cnt_nxt - CNT_W'(SLOT_WIDTH)) : w_cnt_nxt;
  assign w_sample  = w_right ? r_tx_right : r_tx_left;
  assign w_shifted = w_sample << (w_pos - 1'b1);
  assign w_bit     = (w_pos != '0) && (w_pos <= CNT_W'(DATA_WIDTH)) && w_shifted[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {pcm_left, pcm_right};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_bit_cnt  <= CNT_W'(2 * SLOT_WIDTH - 1);
      r_tx_left  <= '0;
      r_tx_right <= '0;
    end else if (!enable) begin
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_bit_cnt  <= CNT_W'(2 * SLOT_WIDTH - 1);
      r_tx_left  <= '0;
      r_tx_right <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_div_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_cnt_nxt;
        r_lrclk   <= w_right;
        r_sdata   <= w_bit;
        if (w_load) begin
          if (w_empty) begin
            r_tx_left  <= '0;
            r_tx_right <= '0;
            r_underrun <= 1'b1;
          end else begin
            {r_tx_left, r_tx_right} <= r_mem[r_rd_ptr];
          end
        end
      end
    end
  end

  assign pcm_ready  = !w_full;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed, table-driven bench for i2s_tx with an I2S receiver model
module tb_i2s_tx;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pcm_left = '0;
  logic [15:0] pcm_right = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ur_stamps[$];
  logic [63:0] frames[$];
  logic [63:0] lrs[$];
  vec_t        tbl [5];

  i2s_tx #(
    .CLK_DIV(4), .DATA_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .fifo_level(fifo_level), .underrun(underrun),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (underrun === 1'b1) ur_stamps.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int k = 0;
    while (frames.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(frames.size() >= target), 64'd1);
  endtask

  // Receiver: samples on BCLK rise, frame starts where LRCLK is first seen low; p0 lands in bit 63
  initial begin : rx
    logic [63:0] fb;
    logic [63:0] lb;
    int          pos;
    logic        prev_lr;
    fb = '0; lb = '0; pos = 99; prev_lr = 1'b1;
    forever begin
      @(posedge i2s_bclk or posedge rst);
      if (rst) begin
        pos = 99;
        prev_lr = 1'b1;
      end else begin
        if (prev_lr && !i2s_lrclk) pos = 0;
        if (pos < 64) begin
          fb = {fb[62:0], i2s_sdata};
          lb = {lb[62:0], i2s_lrclk};
          pos++;
          if (pos == 64) begin
            frames.push_back(fb);
            lrs.push_back(lb);
            pos = 99;
          end
        end
        prev_lr = i2s_lrclk;
      end
    end
  end

  initial begin
    int   n, nb, u0, bad, t_rel;
    logic pl, pb;
    int   t_rise[$];
    int   t_fall[$];

    tbl[0] = '{l: 16'hA5C3, r: 16'h8001, exp: 64'h52E18000_40008000};
    tbl[1] = '{l: 16'hFFFF, r: 16'h0000, exp: 64'h7FFF8000_00000000};
    tbl[2] = '{l: 16'h0001, r: 16'h8000, exp: 64'h00008000_40000000};
    tbl[3] = '{l: 16'h1234, r: 16'hFEDC, exp: 64'h091A0000_7F6E0000};
    tbl[4] = '{l: 16'h5A5A, r: 16'hC3C3, exp: 64'h2D2D0000_61E18000};

    repeat (5) @(negedge clk);
    chk("rst_bclk", 64'(i2s_bclk), 64'd0);
    chk("rst_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("rst_sdata", 64'(i2s_sdata), 64'd0);
    chk("rst_ready", 64'(pcm_ready), 64'd1);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);

    rst = 1'b0;
    enable = 1'b1;
    t_rel = cyc;
    n = 0;
    while (i2s_bclk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("first_rise_clks", 64'(n), 64'd4);
    n = 0;
    while (i2s_bclk === 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("bclk_high_clks", 64'(n), 64'd4);
    n = 0;
    while (i2s_bclk === 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("bclk_low_clks", 64'(n), 64'd4);

    bad = 0;
    pl = i2s_lrclk;
    pb = i2s_bclk;
    repeat (1100) begin
      @(negedge clk);
      if (i2s_lrclk !== pl) begin
        if (!(pb === 1'b1 && i2s_bclk === 1'b0)) bad++;
        if (i2s_lrclk) t_rise.push_back(cyc);
        else t_fall.push_back(cyc);
      end
      pl = i2s_lrclk;
      pb = i2s_bclk;
    end
    chk("lr_edge_on_bclk_fall", 64'(bad), 64'd0);
    chk("lr_rises", 64'(t_rise.size()), 64'd2);
    chk("lr_falls", 64'(t_fall.size()), 64'd2);
    if (t_rise.size() >= 2 && t_fall.size() >= 1) begin
      chk("lr_period", 64'(t_rise[1] - t_rise[0]), 64'd512);
      chk("lr_high", 64'(t_fall[0] - t_rise[0]), 64'd256);
    end

    chk("ur_idle_count", 64'(ur_stamps.size()), 64'd3);
    if (ur_stamps.size() >= 3) begin
      chk("ur_first_delay", 64'(ur_stamps[0] - t_rel), 64'd8);
      chk("ur_gap0", 64'(ur_stamps[1] - ur_stamps[0]), 64'd512);
      chk("ur_gap1", 64'(ur_stamps[2] - ur_stamps[1]), 64'd512);
    end
    chk("idle_frames", 64'(frames.size()), 64'd2);
    foreach (frames[i]) chk("idle_frame_silent", frames[i], 64'd0);

    // Push right after a boundary: the frame must wait for the next one
    n = 0;
    while (ur_stamps.size() < 4 && n < 700) begin @(negedge clk); n++; end
    chk("ur_fourth_seen", 64'(ur_stamps.size()), 64'd4);
    pcm_left = tbl[0].l;
    pcm_right = tbl[0].r;
    pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
    chk("single_level", 64'(fifo_level), 64'd1);
    nb = frames.size();
    wait_frames(nb + 2, 1300, "single_frames_arrive");
    if (frames.size() >= nb + 2) begin
      chk("single_pre_silent", frames[nb], 64'd0);
      chk("single_frame_data", frames[nb + 1], tbl[0].exp);
      chk("single_frame_lrclk", lrs[nb + 1], 64'h00000000_FFFFFFFF);
    end
    chk("single_no_ur", 64'(ur_stamps.size()), 64'd4);
    repeat (10) @(negedge clk);
    chk("ur_resumes", 64'(ur_stamps.size()), 64'd5);
    if (ur_stamps.size() >= 5) chk("ur_skip_gap", 64'(ur_stamps[4] - ur_stamps[3]), 64'd1024);

    // Disable mid left slot, then fill the FIFO with valid held
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_bclk", 64'(i2s_bclk), 64'd0);
    chk("dis_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("dis_sdata", 64'(i2s_sdata), 64'd0);
    chk("dis_level", 64'(fifo_level), 64'd0);
    frames.delete();
    lrs.delete();
    pcm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pcm_left = tbl[i].l;
      pcm_right = tbl[i].r;
      @(negedge clk);
      chk("bp_level", 64'(fifo_level), 64'(i + 1));
      chk("bp_ready", 64'(pcm_ready), 64'(i < 3));
    end
    pcm_left = tbl[4].l;
    pcm_right = tbl[4].r;
    repeat (3) @(negedge clk);
    chk("bp_full_hold", 64'(fifo_level), 64'd4);
    enable = 1'b1;
    u0 = ur_stamps.size();
    n = 0;
    while (pcm_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("bp_ready_after_pop", 64'(n), 64'd8);
    chk("bp_restart_left", 64'(i2s_lrclk), 64'd0);
    chk("bp_level_after_pop", 64'(fifo_level), 64'd3);
    @(negedge clk);
    chk("bp_fifth_accepted", 64'(fifo_level), 64'd4);
    chk("bp_full_again", 64'(pcm_ready), 64'd0);
    pcm_valid = 1'b0;
    wait_frames(5, 5 * 512 + 600, "bp_frames_arrive");
    for (int i = 0; i < 5; i++) begin
      if (i < frames.size()) chk("bp_frame_order", frames[i], tbl[i].exp);
    end
    chk("bp_no_ur", 64'(ur_stamps.size()), 64'(u0));
    repeat (10) @(negedge clk);
    chk("bp_ur_after_drain", 64'(ur_stamps.size()), 64'(u0 + 1));

    // Async reset during a right slot with two frames queued
    for (int i = 1; i < 3; i++) begin
      pcm_left = tbl[i].l;
      pcm_right = tbl[i].r;
      pcm_valid = 1'b1;
      @(negedge clk);
    end
    pcm_valid = 1'b0;
    n = 0;
    while (!(i2s_lrclk === 1'b1 && i2s_bclk === 1'b1) && n < 600) begin @(negedge clk); n++; end
    chk("ar_level_before", 64'(fifo_level), 64'd2);
    chk("ar_in_right_high", 64'(i2s_lrclk & i2s_bclk), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_bclk", 64'(i2s_bclk), 64'd0);
    chk("ar_lrclk", 64'(i2s_lrclk), 64'd1);
    chk("ar_sdata", 64'(i2s_sdata), 64'd0);
    chk("ar_level", 64'(fifo_level), 64'd0);
    chk("ar_ready", 64'(pcm_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t_rel = cyc;
    u0 = ur_stamps.size();
    repeat (10) @(negedge clk);
    chk("ar_fifo_discarded_ur", 64'(ur_stamps.size()), 64'(u0 + 1));
    if (ur_stamps.size() > u0) chk("ar_ur_delay", 64'(ur_stamps[u0] - t_rel), 64'd8);
    chk("ar_level_after", 64'(fifo_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
